// File: rtl/soldier_squad.sv
// soldier_squad: ring-ordered soldier slot manager (push/pop/kill) with per-tick
// horizontal motion, either common clamped march (MODE 0) or per-soldier bounce (MODE 1).
module soldier_squad #(
    parameter int SLOTS     = 16,
    parameter int POS_W     = 10,
    parameter int STEP      = 1,
    parameter int SPAWN_POS = 120,
    parameter int MODE      = 0,
    localparam int IW = $clog2(SLOTS),
    localparam int CW = $clog2(SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   kill_en,
    input  logic [IW-1:0]          kill_idx,
    input  logic                   dir,
    input  logic [POS_W-1:0]       left_bound,
    input  logic [POS_W-1:0]       right_bound,
    output logic [SLOTS-1:0]       valid,
    output logic [SLOTS*POS_W-1:0] pos,
    output logic [SLOTS-1:0]       heading,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   drop
);
    localparam logic [POS_W-1:0] SP = POS_W'(SPAWN_POS);
    localparam logic [POS_W-1:0] S  = POS_W'(STEP);

    logic [IW-1:0]          head, tail, head_n, tail_n, pop_idx;
    logic                   pop_hit, acc, run;
    logic [SLOTS-1:0]       free, valid_n, heading_n, hit;
    logic [SLOTS*POS_W-1:0] pos_n;
    logic [CW-1:0]          count_n, nfree;
    logic [POS_W-1:0]       moved [SLOTS];

    assign run = left_bound <= right_bound;

    // Reaching a bound counts as a hit so a bouncing soldier turns on arrival;
    // positions outside the bounds snap back in on the next move.
    genvar i;
    for (i = 0; i < SLOTS; i++) begin : g_move
        logic [POS_W-1:0] p;
        logic             go_r, hit_r, hit_l;
        assign p        = pos[i*POS_W +: POS_W];
        assign go_r     = (MODE != 0) ? heading[i] : dir;
        assign hit_r    = ({1'b0, p} + {1'b0, S}) >= {1'b0, right_bound};
        assign hit_l    = {1'b0, p} <= ({1'b0, left_bound} + {1'b0, S});
        assign hit[i]   = go_r ? hit_r : hit_l;
        assign moved[i] = go_r ? (hit_r ? right_bound : (p < left_bound ? left_bound : p + S))
                               : (hit_l ? left_bound : (p > right_bound ? right_bound : p - S));
    end

    always_comb begin
        pop_hit = 1'b0;
        pop_idx = head;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (valid[head + IW'(k)]) begin
                pop_hit = pop;
                pop_idx = head + IW'(k);
            end
        end
        free = '0;
        if (pop_hit) free[pop_idx] = 1'b1;
        if (kill_en && valid[kill_idx]) free[kill_idx] = 1'b1;
        acc = push && !valid[tail];
        nfree = '0;
        for (int k = 0; k < SLOTS; k++) nfree = nfree + CW'(free[k]);
        valid_n = valid & ~free;
        if (acc) valid_n[tail] = 1'b1;
        pos_n = pos;
        heading_n = heading;
        for (int k = 0; k < SLOTS; k++) begin
            if (free[k] || (acc && tail == IW'(k))) begin
                pos_n[k*POS_W +: POS_W] = SP;
                heading_n[k] = free[k] ? 1'b0 : dir;
            end else if (tick && run && valid[k]) begin
                pos_n[k*POS_W +: POS_W] = moved[k];
                heading_n[k] = heading[k] ^ hit[k];
            end
            if (MODE == 0) heading_n[k] = valid_n[k] & dir;
        end
        tail_n  = tail + IW'(acc);
        head_n  = pop_hit ? pop_idx + IW'(1) : head;
        count_n = count + CW'(acc) - nfree;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= '0;
            pos     <= {SLOTS{SP}};
            heading <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            drop    <= 1'b0;
        end else begin
            valid   <= valid_n;
            pos     <= pos_n;
            heading <= heading_n;
            head    <= head_n;
            tail    <= tail_n;
            count   <= count_n;
            full    <= valid_n[tail_n];
            empty   <= count_n == '0;
            drop    <= push && valid[tail];
        end
    end
endmodule

// File: tb/tb_soldier_squad.sv
// tb_soldier_squad: directed tests for soldier_squad; instance a = MODE 0 / STEP 4,
// instance b = MODE 1 / STEP 1, both driven by the same commands.
module tb_soldier_squad;
    logic clk = 1'b0, rst = 1'b1;
    logic tick = 0, push = 0, pop = 0, kill_en = 0, dir = 0;
    logic [3:0] kill_idx = '0;
    logic [9:0] left_bound = '0, right_bound = '0;
    logic [15:0] a_valid, a_heading, b_valid, b_heading;
    logic [159:0] a_pos, b_pos;
    logic [4:0] a_count, b_count;
    logic a_full, a_empty, a_drop, b_full, b_empty, b_drop;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    soldier_squad #(.SLOTS(16), .POS_W(10), .STEP(4), .SPAWN_POS(120), .MODE(0)) a (
        .clk(clk), .rst(rst), .tick(tick), .push(push), .pop(pop), .kill_en(kill_en),
        .kill_idx(kill_idx), .dir(dir), .left_bound(left_bound), .right_bound(right_bound),
        .valid(a_valid), .pos(a_pos), .heading(a_heading), .count(a_count),
        .full(a_full), .empty(a_empty), .drop(a_drop));

    soldier_squad #(.SLOTS(16), .POS_W(10), .STEP(1), .SPAWN_POS(120), .MODE(1)) b (
        .clk(clk), .rst(rst), .tick(tick), .push(push), .pop(pop), .kill_en(kill_en),
        .kill_idx(kill_idx), .dir(dir), .left_bound(left_bound), .right_bound(right_bound),
        .valid(b_valid), .pos(b_pos), .heading(b_heading), .count(b_count),
        .full(b_full), .empty(b_empty), .drop(b_drop));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {tick, push, pop, kill_en, dir} = '0;
        kill_idx = '0;
        rst = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++; if (a_valid !== 16'h0) begin n_bad++; $display("FAIL reset_valid got %h want 0000", a_valid); end
        n_cmp++; if (a_count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", a_count); end
        n_cmp++; if ({a_empty, a_full, a_drop} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b want 100", {a_empty, a_full, a_drop}); end
        n_cmp++; if (a_pos !== {16{10'd120}}) begin n_bad++; $display("FAIL reset_pos got %h want all 120", a_pos); end
        n_cmp++; if (b_heading !== 16'h0) begin n_bad++; $display("FAIL reset_heading got %h want 0000", b_heading); end
        do_reset();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        push = 1;
        repeat (16) cyc();
        n_cmp++; if (a_valid !== 16'hFFFF) begin n_bad++; $display("FAIL fill_valid got %h want FFFF", a_valid); end
        n_cmp++; if (a_count !== 5'd16) begin n_bad++; $display("FAIL fill_count got %0d want 16", a_count); end
        n_cmp++; if ({a_full, a_empty, a_drop} !== 3'b100) begin n_bad++; $display("FAIL fill_flags got %b want 100", {a_full, a_empty, a_drop}); end
        cyc();
        n_cmp++; if (a_drop !== 1'b1) begin n_bad++; $display("FAIL overflow_drop got %b want 1", a_drop); end
        n_cmp++; if (a_count !== 5'd16) begin n_bad++; $display("FAIL overflow_count got %0d want 16", a_count); end
        push = 0;
        cyc();
        n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL drop_one_cycle got %b want 0", a_drop); end
        push = 1; pop = 1;
        cyc();
        n_cmp++; if (a_drop !== 1'b1) begin n_bad++; $display("FAIL pushpop_full_drop got %b want 1", a_drop); end
        n_cmp++; if (a_valid !== 16'hFFFE) begin n_bad++; $display("FAIL pushpop_full_valid got %h want FFFE", a_valid); end
        n_cmp++; if ({a_count, a_full} !== {5'd15, 1'b0}) begin n_bad++; $display("FAIL pushpop_full_count got %0d/%b want 15/0", a_count, a_full); end
        push = 0; pop = 0;
    endtask

    task automatic test_kill_pop();
        do_reset();
        push = 1;
        repeat (4) cyc();
        push = 0; kill_en = 1; kill_idx = 4'd0;
        cyc();
        n_cmp++; if (a_valid !== 16'h000E) begin n_bad++; $display("FAIL kill0_valid got %h want 000E", a_valid); end
        n_cmp++; if (a_pos[9:0] !== 10'd120) begin n_bad++; $display("FAIL kill0_pos got %0d want 120", a_pos[9:0]); end
        kill_en = 0; pop = 1;
        cyc();
        n_cmp++; if (a_valid !== 16'h000C) begin n_bad++; $display("FAIL pop_skip_valid got %h want 000C", a_valid); end
        kill_en = 1; kill_idx = 4'd2;
        cyc();
        n_cmp++; if (a_valid !== 16'h0008) begin n_bad++; $display("FAIL popkill_same_valid got %h want 0008", a_valid); end
        n_cmp++; if (a_count !== 5'd1) begin n_bad++; $display("FAIL popkill_same_count got %0d want 1", a_count); end
        kill_en = 0; pop = 0; push = 1;
        cyc();
        n_cmp++; if (a_valid !== 16'h0018) begin n_bad++; $display("FAIL push_slot4 got %h want 0018", a_valid); end
        push = 0; pop = 1; kill_en = 1; kill_idx = 4'd4;
        cyc();
        n_cmp++; if ({a_valid, a_count, a_empty} !== {16'h0, 5'd0, 1'b1}) begin n_bad++; $display("FAIL popkill_diff got %h/%0d/%b want 0000/0/1", a_valid, a_count, a_empty); end
        kill_en = 0;
        cyc();
        n_cmp++; if ({a_valid, a_count} !== {16'h0, 5'd0}) begin n_bad++; $display("FAIL pop_empty got %h/%0d want 0000/0", a_valid, a_count); end
        pop = 0; push = 1;
        cyc();
        push = 0; kill_en = 1; kill_idx = 4'd0;
        cyc();
        n_cmp++; if ({a_valid, a_count} !== {16'h0020, 5'd1}) begin n_bad++; $display("FAIL kill_invalid got %h/%0d want 0020/1", a_valid, a_count); end
        kill_en = 0;
    endtask

    task automatic test_mode0_clamp();
        logic [9:0] exp_pos [4];
        exp_pos = '{10'd124, 10'd128, 10'd130, 10'd130};
        do_reset();
        left_bound = 10'd100; right_bound = 10'd130; dir = 1; push = 1;
        cyc();
        push = 0;
        n_cmp++; if ({a_pos[9:0], a_heading} !== {10'd120, 16'h0001}) begin n_bad++; $display("FAIL m0_spawn got %0d/%h want 120/0001", a_pos[9:0], a_heading); end
        tick = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_cmp++; if (a_pos[9:0] !== exp_pos[k]) begin n_bad++; $display("FAIL m0_tick%0d got %0d want %0d", k, a_pos[9:0], exp_pos[k]); end
        end
        dir = 0;
        cyc();
        n_cmp++; if ({a_pos[9:0], a_heading} !== {10'd126, 16'h0000}) begin n_bad++; $display("FAIL m0_left got %0d/%h want 126/0000", a_pos[9:0], a_heading); end
        tick = 0;
    endtask

    task automatic test_mode1_bounce();
        logic [9:0] exp_pos [7];
        logic       exp_hd  [7];
        exp_pos = '{10'd121, 10'd122, 10'd121, 10'd120, 10'd119, 10'd118, 10'd119};
        exp_hd  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        left_bound = 10'd118; right_bound = 10'd122; dir = 1; push = 1;
        cyc();
        push = 0; dir = 0; tick = 1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            n_cmp++; if ({b_pos[9:0], b_heading[0]} !== {exp_pos[k], exp_hd[k]}) begin n_bad++; $display("FAIL m1_tick%0d got %0d/%b want %0d/%b", k, b_pos[9:0], b_heading[0], exp_pos[k], exp_hd[k]); end
        end
        tick = 0;
    endtask

    task automatic test_push_tick();
        do_reset();
        left_bound = 10'd100; right_bound = 10'd130; dir = 1; push = 1;
        cyc();
        tick = 1;
        cyc();
        push = 0;
        n_cmp++; if ({a_pos[19:10], a_pos[9:0], a_count} !== {10'd120, 10'd124, 5'd2}) begin n_bad++; $display("FAIL push_tick got %0d,%0d/%0d want 120,124/2", a_pos[19:10], a_pos[9:0], a_count); end
        left_bound = 10'd130; right_bound = 10'd100;
        cyc();
        n_cmp++; if ({a_pos[19:10], a_pos[9:0]} !== {10'd120, 10'd124}) begin n_bad++; $display("FAIL inverted_hold got %0d,%0d want 120,124", a_pos[19:10], a_pos[9:0]); end
        left_bound = 10'd100; right_bound = 10'd130;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({a_valid, a_count, a_empty, a_full, a_drop} !== {16'h0, 5'd0, 3'b100}) begin n_bad++; $display("FAIL async_rst_state got %h/%0d/%b want 0000/0/100", a_valid, a_count, {a_empty, a_full, a_drop}); end
        n_cmp++; if ({a_pos, a_heading} !== {{16{10'd120}}, 16'h0}) begin n_bad++; $display("FAIL async_rst_pos got %h want all 120", a_pos); end
        tick = 0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_kill_pop();
        test_mode0_clamp();
        test_mode1_bounce();
        test_push_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/soldier_squad.md
# soldier_squad

Parametrised squad manager for marching sprites. It allocates soldiers into `SLOTS` slots using a ring-ordered queue with push, pop and kill-by-index. It advances every live soldier's horizontal position on a single-cycle `tick` enable, either all in a common direction with clamping or each bouncing on its own heading. It sits between game control (spawn, retreat, hit detection) and the VGA renderer, which consumes `valid`, `pos` and `heading`. The whole block runs on one clock; it is the generalised successor of the fixed 16-soldier queue.

## Interface

Parameters:

- `SLOTS`, 16: number of soldier slots; power of two, at least 2.
- `POS_W`, 10: position width.
- `STEP`, 1: pixels moved per `tick`; must be below 2^(POS_W-1).
- `SPAWN_POS`, 120: position loaded on spawn, free and reset.
- `MODE`, 0: 0 = common march with clamping; 1 = per-soldier bounce.

Ports (`IW` = clog2(`SLOTS`), `CW` = clog2(`SLOTS`+1)):

- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: movement enable, one cycle per motion step (from the game-rate divider).
- `push` in 1: spawn one soldier.
- `pop` in 1: remove the oldest live soldier.
- `kill_en` in 1: remove the soldier at `kill_idx`.
- `kill_idx` in IW: slot to kill.
- `dir` in 1: 0 = left, 1 = right. In MODE 0 it is the march direction; in MODE 1 it is the heading given to a spawned soldier.
- `left_bound`, `right_bound` in POS_W: motion limits, inclusive.
- `valid` out SLOTS: slot-live mask.
- `pos` out SLOTS*POS_W: slot i is at `pos[i*POS_W +: POS_W]`.
- `heading` out SLOTS: per-slot heading. In MODE 0 it mirrors `dir` for live slots.
- `count` out CW: number of live soldiers.
- `full` out 1: equals `valid[tail]`; push is blocked while high.
- `empty` out 1: equals (`count` == 0).
- `drop` out 1: one-cycle pulse when a push is rejected.

## Operation

- Internal state: `head` and `tail` pointers (IW bits, wrapping modulo `SLOTS`), plus per-slot `valid`, `pos` and `heading` registers.
- Every decision is made from pre-edge state, and all outputs are registered.
- **Push:** if `valid[tail]` is 0, then `valid[tail]` becomes 1, `pos[tail]` becomes `SPAWN_POS`, `heading[tail]` becomes `dir`, and `tail` increments. Otherwise the push is ignored and `drop` pulses. Slots freed elsewhere in the ring do not unblock a push.
- **Pop:** frees the first valid slot found scanning from `head` in ring order, and sets `head` to that slot + 1. When `empty`, pop is a no-op that leaves `head` unchanged.
- **Kill:** if `valid[kill_idx]` is set, that slot is cleared. Pointers are unchanged. Killing an invalid slot is a no-op.
- **Freed slot:** `valid` = 0, `pos` = `SPAWN_POS`, `heading` = 0. Invalid slots never move.
- **Simultaneous events:**
  - Pop and kill on the same slot free it once; `count` drops by 1.
  - Pop and kill on different slots free both; `count` drops by 2.
  - Push plus pop while `full`: the push is still rejected, because the decision uses pre-edge `full`.
  - A push landing on a slot freed in the same cycle is impossible, since push requires that slot already free.
- **`count`:** next value = count + accepted push − distinct slots freed.
- **Motion:** on `tick`, every slot that is valid pre-edge and not freed this cycle moves. A slot spawned this cycle does not move until the next `tick`.
  - MODE 0, left: new pos = (pos < `left_bound` + `STEP`) ? `left_bound` : pos − `STEP`.
  - MODE 0, right: new pos = (pos + `STEP` > `right_bound`) ? `right_bound` : pos + `STEP`.
  - Compute at POS_W+1 bits so there is no wrap.
  - MODE 1: move per the slot's own heading. When a clamp is hit, pos = bound and heading flips. A soldier already sitting at the bound flips and moves away on the following tick.
  - A soldier outside the bounds (after the bounds change) is clamped on its next tick.
  - When `left_bound` > `right_bound`, motion is suppressed and all positions hold.

## Timing

- Reset (asynchronous assert):
  - `valid` = 0, all `pos` = `SPAWN_POS`, `heading` = 0.
  - `head` = `tail` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `drop` = 0.
- Release is synchronous to `clk`. The first command takes effect at the first edge after release.
- Latency: push, pop, kill and motion results are all visible one cycle after the sampling edge. `drop` is asserted in that same cycle for exactly one cycle.
- `full`, `empty` and `count` are consistent with `valid` in every cycle.
- Reset asserted mid-operation clears all state immediately. No partial move completes.

## Test plan

- **Fill and overflow:** reset, then 17 consecutive pushes with SLOTS=16 → `valid` = 16'hFFFF, `count` = 16, `full` = 1; the 17th push gives a one-cycle `drop` pulse and `count` stays 16.
- **Kill hole and pop skip:**
  - Push 4, kill slot 0 → `valid` = 4'b1110.
  - Pop → slot 1 freed, `valid` = 4'b1100, `head` = 2.
  - Pop + kill 2 in the same cycle → `valid` = 4'b1000, `count` = 1.
- **MODE 0 clamp:** one soldier, bounds 100..130, `dir` = 1, `STEP` = 4 → 120, 124, 128, 130, 130 over successive ticks. Then `dir` = 0 → 126.
- **MODE 1 bounce:** bounds 118..122, `STEP` = 1, spawn with `dir` = 1 → 121, 122 (heading flips to 0), 121, 120, 119, 118 (heading flips to 1), 119.
- **Simultaneous edge cases:**
  - Push together with `tick` → the new soldier stays at 120 while existing soldiers move.
  - Push + pop while full → `drop` = 1 and the oldest slot is freed.
  - Assert `rst` low mid-tick → all outputs return to reset values asynchronously.
